// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - opcode and funct encodings decoded by mdu_control
//   - FSM state enum (ACC is only reached when MDU_MADD_EN is defined)
//   - default operand width
// Optional feature macro: MDU_MADD_EN (SPECIAL2 madd/maddu/msub/msubu).
package mdu_pkg;

  localparam int MDU_DATA_W = 32;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  // SPECIAL funct codes
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // SPECIAL2 funct codes (multiply-accumulate)
  localparam logic [5:0] FN_MADD  = 6'b000000;
  localparam logic [5:0] FN_MADDU = 6'b000001;
  localparam logic [5:0] FN_MSUB  = 6'b000100;
  localparam logic [5:0] FN_MSUBU = 6'b000101;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    ACC
  } state_t;

endpackage

// File: rtl/mdu_control_if.sv
// mdu_control_if: EX-stage to multiply/divide unit connection.
//   master (pipeline side): drives flush, op_valid, alu_op, alu_funct,
//                           src_a, src_b; observes the unit's outputs.
//   slave  (mdu_control):   drives busy, result, result_valid, hi, lo,
//                           div_by_zero.
interface mdu_control_if
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
);

  logic              flush;
  logic              op_valid;
  logic [5:0]        alu_op;
  logic [5:0]        alu_funct;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              div_by_zero;

  modport master (
    output flush, op_valid, alu_op, alu_funct, src_a, src_b,
    input  busy, result, result_valid, hi, lo, div_by_zero
  );

  modport slave (
    input  flush, op_valid, alu_op, alu_funct, src_a, src_b,
    output busy, result, result_valid, hi, lo, div_by_zero
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one iteration of the iterative multiply/divide datapath,
// resolving BITS_PER_CYCLE bits combinationally.
//   is_div          1: restoring divide step, 0: shift-add multiply step
//   operand         multiplicand magnitude or divisor magnitude
//   hi_in / lo_in   current partial state
//                   multiply: hi = running upper product, lo = multiplier
//                             being shifted out / product bits shifted in
//                   divide:   hi = partial remainder, lo = dividend being
//                             shifted out / quotient bits shifted in
//   hi_out / lo_out state after BITS_PER_CYCLE bits
module mdu_step #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  // One extra bit holds the multiply carry or the divide trial difference.
  logic [DATA_W:0] wide;

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    wide   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        // Remainder stays below the divisor, so the trial value fits DATA_W+1 bits.
        wide = {hi_out, lo_out[DATA_W-1]};
        if (wide >= {1'b0, operand}) begin
          wide   = wide - {1'b0, operand};
          lo_out = {lo_out[DATA_W-2:0], 1'b1};
        end else begin
          lo_out = {lo_out[DATA_W-2:0], 1'b0};
        end
        hi_out = wide[DATA_W-1:0];
      end else begin
        wide   = {1'b0, hi_out} + (lo_out[0] ? {1'b0, operand} : '0);
        lo_out = {wide[0], lo_out[DATA_W-1:1]};
        hi_out = wide[DATA_W:1];
      end
    end
  end

endmodule

// File: rtl/mdu_control.sv
// mdu_control: MIPS32 multiply/divide unit beside the EX-stage ALU.
// Decodes SPECIAL mult/multu/div/divu/mfhi/mflo/mthi/mtlo, runs an
// iterative shift-add multiply or restoring divide on operand magnitudes,
// applies the sign fix-up in FIX, and owns HI/LO.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mdu_control_if.slave (flush, op_valid, alu_op, alu_funct,
//          src_a, src_b in; busy, result, result_valid, hi, lo,
//          div_by_zero out)
// Optional feature macro: MDU_MADD_EN adds SPECIAL2 madd/maddu/msub/msubu,
// which insert one ACC cycle after FIX to fold the product into HI:LO.
module mdu_control
  import mdu_pkg::*;
#(
  parameter int DATA_W         = MDU_DATA_W,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mdu_control_if.slave  bus
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t state, state_next;

  logic [DATA_W-1:0] hi_q, lo_q, result_q;
  logic              result_valid_q, div_by_zero_q, busy_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] acc_hi_q, acc_lo_q, operand_q;
  logic              op_div_q, neg_res_q, neg_rem_q;
`ifdef MDU_MADD_EN
  logic              op_acc_q, op_sub_q;
`endif

  logic dec_mul, dec_div, dec_signed, dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
`ifdef MDU_MADD_EN
  logic dec_acc, dec_sub;
`endif
  logic accept, op_known;
  logic a_neg, b_neg, b_zero;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [2*DATA_W-1:0] prod_raw, prod_fixed;

  logic ld_mul, ld_div, ld_div0, do_step, do_fix;
  logic do_mthi, do_mtlo, do_mfhi, do_mflo;
`ifdef MDU_MADD_EN
  logic do_acc;
`endif

  // Instruction decode; unrecognised opcode/funct leaves every flag low,
  // so such an instruction is consumed without any effect.
  always_comb begin
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    dec_mfhi   = 1'b0;
    dec_mflo   = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
`ifdef MDU_MADD_EN
    dec_acc    = 1'b0;
    dec_sub    = 1'b0;
`endif
    if (bus.alu_op == OP_SPECIAL) begin
      case (bus.alu_funct)
        FN_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
        FN_MULTU: dec_mul  = 1'b1;
        FN_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
        FN_DIVU:  dec_div  = 1'b1;
        FN_MFHI:  dec_mfhi = 1'b1;
        FN_MFLO:  dec_mflo = 1'b1;
        FN_MTHI:  dec_mthi = 1'b1;
        FN_MTLO:  dec_mtlo = 1'b1;
        default:  ;
      endcase
    end
`ifdef MDU_MADD_EN
    else if (bus.alu_op == OP_SPECIAL2) begin
      case (bus.alu_funct)
        FN_MADD:  begin dec_mul = 1'b1; dec_acc = 1'b1; dec_signed = 1'b1; end
        FN_MADDU: begin dec_mul = 1'b1; dec_acc = 1'b1; end
        FN_MSUB:  begin dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; dec_signed = 1'b1; end
        FN_MSUBU: begin dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
        default:  ;
      endcase
    end
`endif
  end

  // Accept condition and operand magnitudes for the iterative engine.
  always_comb begin
`ifdef MDU_MADD_EN
    op_known = (bus.alu_op == OP_SPECIAL) || (bus.alu_op == OP_SPECIAL2);
`else
    op_known = (bus.alu_op == OP_SPECIAL);
`endif
    accept = bus.op_valid & ~busy_q & ~bus.flush & op_known;
    a_neg  = dec_signed & bus.src_a[DATA_W-1];
    b_neg  = dec_signed & bus.src_b[DATA_W-1];
    mag_a  = a_neg ? -bus.src_a : bus.src_a;
    mag_b  = b_neg ? -bus.src_b : bus.src_b;
    b_zero = (bus.src_b == '0);
  end

  mdu_step #(
    .DATA_W         (DATA_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_div  (op_div_q),
    .operand (operand_q),
    .hi_in   (acc_hi_q),
    .lo_in   (acc_lo_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // Signed multiply results are negated when the operand signs differed.
  always_comb begin
    prod_raw   = {acc_hi_q, acc_lo_q};
    prod_fixed = neg_res_q ? -prod_raw : prod_raw;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state; flush wins over everything, including a same-cycle accept.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && dec_mul)                 state_next = MUL;
          else if (accept && dec_div && !b_zero) state_next = DIV;
        end
        MUL, DIV: if (count_q == '0) state_next = FIX;
`ifdef MDU_MADD_EN
        FIX:     state_next = op_acc_q ? ACC : IDLE;
`else
        FIX:     state_next = IDLE;
`endif
        ACC:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: one-cycle strobes that steer the datapath register block.
  always_comb begin
    ld_mul  = 1'b0;
    ld_div  = 1'b0;
    ld_div0 = 1'b0;
    do_step = 1'b0;
    do_fix  = 1'b0;
    do_mthi = 1'b0;
    do_mtlo = 1'b0;
    do_mfhi = 1'b0;
    do_mflo = 1'b0;
`ifdef MDU_MADD_EN
    do_acc  = 1'b0;
`endif
    if (!bus.flush) begin
      case (state)
        IDLE: begin
          ld_mul  = accept & dec_mul;
          ld_div  = accept & dec_div & ~b_zero;
          ld_div0 = accept & dec_div & b_zero;
          do_mthi = accept & dec_mthi;
          do_mtlo = accept & dec_mtlo;
          do_mfhi = accept & dec_mfhi;
          do_mflo = accept & dec_mflo;
        end
        MUL, DIV: do_step = 1'b1;
        FIX:      do_fix  = 1'b1;
`ifdef MDU_MADD_EN
        ACC:      do_acc  = 1'b1;
`endif
        default:  ;
      endcase
    end
  end

  // Datapath: HI/LO, read-back, pulses, iteration state and busy.
  // busy is registered from the next state so it covers the N iteration
  // cycles plus FIX (and ACC), and the single divide-by-zero cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q           <= '0;
      lo_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
      busy_q         <= 1'b0;
      count_q        <= '0;
      acc_hi_q       <= '0;
      acc_lo_q       <= '0;
      operand_q      <= '0;
      op_div_q       <= 1'b0;
      neg_res_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
`ifdef MDU_MADD_EN
      op_acc_q       <= 1'b0;
      op_sub_q       <= 1'b0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
      busy_q         <= (state_next != IDLE) | ld_div0;

      if (do_mthi) hi_q <= bus.src_a;
      if (do_mtlo) lo_q <= bus.src_a;
      if (do_mfhi) begin result_q <= hi_q; result_valid_q <= 1'b1; end
      if (do_mflo) begin result_q <= lo_q; result_valid_q <= 1'b1; end

      if (ld_div0) begin
        hi_q          <= bus.src_a;
        lo_q          <= '1;
        div_by_zero_q <= 1'b1;
      end

      if (ld_mul || ld_div) begin
        acc_hi_q  <= '0;
        acc_lo_q  <= ld_mul ? mag_b : mag_a;
        operand_q <= ld_mul ? mag_a : mag_b;
        op_div_q  <= ld_div;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        count_q   <= CNT_LAST;
`ifdef MDU_MADD_EN
        op_acc_q  <= dec_acc;
        op_sub_q  <= dec_sub;
`endif
      end

      if (do_step) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        if (count_q != '0) count_q <= count_q - CNT_W'(1);
      end

      if (do_fix) begin
        if (op_div_q) begin
          lo_q <= neg_res_q ? -acc_lo_q : acc_lo_q;
          hi_q <= neg_rem_q ? -acc_hi_q : acc_hi_q;
        end
`ifdef MDU_MADD_EN
        else if (op_acc_q) begin
          // Keep the signed product for the following ACC cycle.
          {acc_hi_q, acc_lo_q} <= prod_fixed;
        end
`endif
        else begin
          {hi_q, lo_q} <= prod_fixed;
        end
      end

`ifdef MDU_MADD_EN
      if (do_acc) begin
        {hi_q, lo_q} <= op_sub_q ? ({hi_q, lo_q} - prod_raw)
                                 : ({hi_q, lo_q} + prod_raw);
      end
`endif
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.div_by_zero  = div_by_zero_q;

endmodule

// File: tb/tb_mdu_control.sv
// tb_mdu_control: directed self-checking bench for mdu_control
// (default build, 32-bit operands, one bit per cycle).
module tb_mdu_control;
  import mdu_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   compare_count  = 0;
  int   mismatch_count = 0;
  int   cycles;

  mdu_control_if #(.DATA_W(DW)) bus ();

  mdu_control #(
    .DATA_W         (DW),
    .BITS_PER_CYCLE (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one accept edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.op_valid  = 1'b1;
    bus.alu_op    = op;
    bus.alu_funct = funct;
    bus.src_a     = a;
    bus.src_b     = b;
    tick();
    bus.op_valid  = 1'b0;
    bus.src_a     = 32'hDEAD_BEEF;
    bus.src_b     = 32'h0BAD_F00D;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      mismatch_count++;
      $error("[TB] FAIL %s: observed 0x%08h, required 0x%08h", tag, observed, expected);
    end
  endtask

  // Count cycles until busy drops, bounded so a stuck unit cannot hang the run.
  task automatic waitIdle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Hold an instruction until the read-back pulse appears (bounded).
  task automatic holdUntilResult(input logic [5:0] funct, output int n);
    bus.op_valid  = 1'b1;
    bus.alu_op    = OP_SPECIAL;
    bus.alu_funct = funct;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.result_valid && n < 200);
    bus.op_valid = 1'b0;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.op_valid  = 1'b0;
    bus.alu_op    = 6'd0;
    bus.alu_funct = 6'd0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    rst_n         = 1'b0;

    // Reset state
    #3;
    checkOutput("reset_busy",   32'(bus.busy), 32'd0);
    checkOutput("reset_result", bus.result, 32'd0);
    checkOutput("reset_rvalid", 32'(bus.result_valid), 32'd0);
    checkOutput("reset_hi",     bus.hi, 32'd0);
    checkOutput("reset_lo",     bus.lo, 32'd0);
    checkOutput("reset_dbz",    32'(bus.div_by_zero), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // Signed multiply -2 * 3
    $display("[TB] mult 0xFFFFFFFE * 3");
    applyStimulus(OP_SPECIAL, FN_MULT, 32'hFFFF_FFFE, 32'd3);
    waitIdle(cycles);
    checkOutput("mult_busy_cycles", 32'(cycles), 32'd33);
    checkOutput("mult_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // Unsigned multiply, same operands
    applyStimulus(OP_SPECIAL, FN_MULTU, 32'hFFFF_FFFE, 32'd3);
    waitIdle(cycles);
    checkOutput("multu_busy_cycles", 32'(cycles), 32'd33);
    checkOutput("multu_hi", bus.hi, 32'h0000_0002);
    checkOutput("multu_lo", bus.lo, 32'hFFFF_FFFA);

    // Unknown SPECIAL funct (add): consumed with no effect
    applyStimulus(OP_SPECIAL, 6'b100000, 32'h1111_1111, 32'h2222_2222);
    checkOutput("unknown_busy",   32'(bus.busy), 32'd0);
    checkOutput("unknown_rvalid", 32'(bus.result_valid), 32'd0);
    checkOutput("unknown_hi",     bus.hi, 32'h0000_0002);

    // Signed divide -7 / 2
    applyStimulus(OP_SPECIAL, FN_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle(cycles);
    checkOutput("div_busy_cycles", 32'(cycles), 32'd33);
    checkOutput("div_lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", bus.hi, 32'hFFFF_FFFF);

    // Unsigned divide 100 / 7
    applyStimulus(OP_SPECIAL, FN_DIVU, 32'd100, 32'd7);
    waitIdle(cycles);
    checkOutput("divu_lo", bus.lo, 32'd14);
    checkOutput("divu_hi", bus.hi, 32'd2);

    // Divide by zero
    applyStimulus(OP_SPECIAL, FN_DIVU, 32'd7, 32'd0);
    checkOutput("dbz_pulse", 32'(bus.div_by_zero), 32'd1);
    checkOutput("dbz_busy",  32'(bus.busy), 32'd1);
    checkOutput("dbz_hi",    bus.hi, 32'd7);
    checkOutput("dbz_lo",    bus.lo, 32'hFFFF_FFFF);
    waitIdle(cycles);
    checkOutput("dbz_busy_cycles", 32'(cycles), 32'd1);
    checkOutput("dbz_pulse_end",   32'(bus.div_by_zero), 32'd0);

    // Signed MIN / -1 wraps, no flag
    applyStimulus(OP_SPECIAL, FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(cycles);
    checkOutput("minneg_lo",  bus.lo, 32'h8000_0000);
    checkOutput("minneg_hi",  bus.hi, 32'd0);
    checkOutput("minneg_dbz", 32'(bus.div_by_zero), 32'd0);

    // mult 5*6 followed immediately by held mfhi, then mflo
    applyStimulus(OP_SPECIAL, FN_MULT, 32'd5, 32'd6);
    holdUntilResult(FN_MFHI, cycles);
    checkOutput("mfhi_wait_cycles", 32'(cycles), 32'd34);
    checkOutput("mfhi_rvalid", 32'(bus.result_valid), 32'd1);
    checkOutput("mfhi_result", bus.result, 32'd0);
    holdUntilResult(FN_MFLO, cycles);
    checkOutput("mflo_wait_cycles", 32'(cycles), 32'd1);
    checkOutput("mflo_result", bus.result, 32'd30);
    tick();
    checkOutput("mflo_rvalid_end", 32'(bus.result_valid), 32'd0);

    // mthi, then mult abandoned by flush at cycle 10
    applyStimulus(OP_SPECIAL, FN_MTHI, 32'h0000_1234, 32'd0);
    checkOutput("mthi_hi",   bus.hi, 32'h0000_1234);
    checkOutput("mthi_busy", 32'(bus.busy), 32'd0);
    applyStimulus(OP_SPECIAL, FN_MULT, 32'd7, 32'd9);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checkOutput("flush_busy", 32'(bus.busy), 32'd0);
    checkOutput("flush_hi",   bus.hi, 32'h0000_1234);
    // Flush outranks a same-cycle accept
    bus.flush = 1'b1;
    applyStimulus(OP_SPECIAL, FN_MTHI, 32'h0000_BEEF, 32'd0);
    bus.flush = 1'b0;
    checkOutput("flush_prio_hi", bus.hi, 32'h0000_1234);
    repeat (40) tick();
    checkOutput("flush_later_hi", bus.hi, 32'h0000_1234);
    checkOutput("flush_later_lo", bus.lo, 32'd30);

    // Asynchronous reset in the middle of a divide
    applyStimulus(OP_SPECIAL, FN_DIVU, 32'd100, 32'd3);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_busy",   32'(bus.busy), 32'd0);
    checkOutput("areset_hi",     bus.hi, 32'd0);
    checkOutput("areset_lo",     bus.lo, 32'd0);
    checkOutput("areset_result", bus.result, 32'd0);
    checkOutput("areset_rvalid", 32'(bus.result_valid), 32'd0);
    checkOutput("areset_dbz",    32'(bus.div_by_zero), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // Unit usable after reset
    applyStimulus(OP_SPECIAL, FN_MTLO, 32'h0000_00A5, 32'd0);
    checkOutput("post_reset_lo", bus.lo, 32'h0000_00A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
